mini_fir_serial: RTL

- Parametrised, time-multiplexed FIR filter built around a single multiply-accumulate unit.
- Holds a TAPS-deep sample delay line and a TAPS-entry coefficient register file.
- Computes one output per accepted input sample over TAPS cycles, with valid/ready handshakes on both sides.
- Sits between the sample source and downstream decimation/output logic in the mini DSP datapath.

---
 rtl/mini_fir_serial_pkg.sv | 18 +
 rtl/mini_fir_mac_unit.sv | 46 ++++
 rtl/mini_fir_serial.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mini_fir_serial_pkg.sv
// Shared definitions for the mini DSP FIR filter.
//   - Default width constants, also used by the neighbouring mini DSP blocks.
//   - FSM state encoding for the serial FIR controller.
package mini_fir_serial_pkg;

  // Default widths shared across the mini DSP datapath.
  localparam int unsigned FirDataW  = 8;
  localparam int unsigned FirCoeffW = 8;
  localparam int unsigned FirTaps   = 8;

  // Controller states; encodings are fixed so other blocks can decode o_busy phases.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } fir_state_e;

endpackage

// File: rtl/mini_fir_mac_unit.sv
// Single multiply-accumulate step of the serial FIR filter.
// Purely combinational: acc_out = acc_in + sample * coeff, modulo 2^ACC_W.
// The signed/unsigned operand extension rules live here and nowhere else.
//
// Ports:
//   sample   in  DATA_W   delay-line sample
//   coeff    in  COEFF_W  coefficient
//   acc_in   in  ACC_W    running accumulator
//   acc_out  out ACC_W    accumulator plus product
//
// ACC_W must be greater than DATA_W + COEFF_W.
module mini_fir_mac_unit #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COEFF_W = 8,
  parameter int unsigned ACC_W   = 19,
  parameter int unsigned SIGNED  = 0
) (
  input  logic [DATA_W-1:0]  sample,
  input  logic [COEFF_W-1:0] coeff,
  input  logic [ACC_W-1:0]   acc_in,
  output logic [ACC_W-1:0]   acc_out
);

  localparam int unsigned ProdW = DATA_W + COEFF_W;

  logic [ProdW-1:0] sample_ext;
  logic [ProdW-1:0] coeff_ext;
  logic [ProdW-1:0] prod;
  logic [ACC_W-1:0] prod_ext;

  if (SIGNED != 0) begin : g_signed
    // The low ProdW bits of a product of sign-extended operands are the exact two's-complement
    // product, since any DATA_W x COEFF_W signed product fits in ProdW bits.
    assign sample_ext = {{COEFF_W{sample[DATA_W-1]}}, sample};
    assign coeff_ext  = {{DATA_W{coeff[COEFF_W-1]}}, coeff};
    assign prod_ext   = {{(ACC_W-ProdW){prod[ProdW-1]}}, prod};
  end else begin : g_unsigned
    assign sample_ext = {{COEFF_W{1'b0}}, sample};
    assign coeff_ext  = {{DATA_W{1'b0}}, coeff};
    assign prod_ext   = {{(ACC_W-ProdW){1'b0}}, prod};
  end

  assign prod    = sample_ext * coeff_ext;
  assign acc_out = acc_in + prod_ext;

endmodule

// File: rtl/mini_fir_serial.sv
// Time-multiplexed FIR filter with one shared multiply-accumulate unit.
//
// One sample is accepted in IDLE, then TAPS products are accumulated one per cycle in MAC, and
// the result is offered in OUT until downstream takes it. x[0] is always the newest sample and is
// weighted by c[0].
//
// Optional feature (macro MINI_FIR_FLUSH_EN): adds i_flush, which zeroes the delay line when the
// block is idle. A flush in the same cycle as a presented sample wins and the sample is not taken.
//
// Ports:
//   clk      in   1             clock
//   rst_n    in   1             asynchronous active-low reset
//   i_valid  in   1             input sample valid
//   o_ready  out  1             block can accept a sample (IDLE only)
//   i_data   in   DATA_W        input sample
//   i_cwe    in   1             coefficient write enable (honoured in IDLE only)
//   i_caddr  in   $clog2(TAPS)  coefficient index
//   i_cdata  in   COEFF_W       coefficient value
//   i_flush  in   1             delay-line flush (MINI_FIR_FLUSH_EN only)
//   o_valid  out  1             result valid
//   i_ready  in   1             downstream accepts result
//   o_data   out  ACC_W         filter output, holds last result
//   o_busy   out  1             controller is in MAC or OUT
module mini_fir_serial
  import mini_fir_serial_pkg::*;
#(
  parameter int unsigned DATA_W  = FirDataW,
  parameter int unsigned COEFF_W = FirCoeffW,
  parameter int unsigned TAPS    = FirTaps,
  parameter int unsigned SIGNED  = 0,
  parameter int unsigned ACC_W   = DATA_W + COEFF_W + $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_cwe,
  input  logic [$clog2(TAPS)-1:0] i_caddr,
  input  logic [COEFF_W-1:0]      i_cdata,
`ifdef MINI_FIR_FLUSH_EN
  input  logic                    i_flush,
`endif
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [ACC_W-1:0]        o_data,
  output logic                    o_busy
);

  localparam int unsigned IdxW = $clog2(TAPS);
  localparam logic [IdxW:0] TapsW = (IdxW + 1)'(TAPS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TAPS - 1);

  fir_state_e state_q, state_d;

  logic [DATA_W-1:0]  x_q [TAPS];
  logic [COEFF_W-1:0] c_q [TAPS];
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   o_data_q;
  logic [IdxW-1:0]    idx_q;
  logic               o_valid_q;

  logic idle;
  logic flush;
  logic accept;
  logic coef_we;
  logic last_tap;

  assign idle = (state_q == StIdle);

`ifdef MINI_FIR_FLUSH_EN
  assign flush = idle && i_flush;
`else
  assign flush = 1'b0;
`endif

  // Flush takes priority over a presented sample, so ready is withdrawn for that cycle.
  assign o_ready  = idle && !flush;
  assign accept   = o_ready && i_valid;
  // Out-of-range indices are dropped; the compare folds away when TAPS is a power of two.
  assign coef_we  = idle && i_cwe && ({1'b0, i_caddr} < TapsW);
  assign last_tap = (idx_q == LastIdx);

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_busy  = !idle;

  mini_fir_mac_unit #(
    .DATA_W  (DATA_W),
    .COEFF_W (COEFF_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED)
  ) u_mac (
    .sample  (x_q[idx_q]),
    .coeff   (c_q[idx_q]),
    .acc_in  (acc_q),
    .acc_out (acc_next)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept)   state_d = StMac;
      StMac:  if (last_tap) state_d = StOut;
      StOut:  if (i_ready)  state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, tap index and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      idx_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_next;
          idx_q <= idx_q + IdxW'(1);
          if (last_tap) begin
            o_data_q  <= acc_next;
            o_valid_q <= 1'b1;
          end
        end
        StOut: begin
          if (i_ready) begin
            o_valid_q <= 1'b0;
          end
        end
        default: begin
          o_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sample delay line: x[0] is the newest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        x_q[k] <= x_q[k-1];
      end
      x_q[0] <= i_data;
    end
  end

  // Coefficient register file. A write coinciding with an accept is already in place when the
  // first product is formed, so it applies to that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        c_q[k] <= '0;
      end
    end else if (coef_we) begin
      c_q[i_caddr] <= i_cdata;
    end
  end

endmodule
